uart_alu_core: RTL and testbench
================================

# uart_alu_core

Byte-stream command processor that sits between the `uart_rx` master stream and the `uart_tx` slave stream in the iCE40 UART ALU top level. It replaces the plain receive-to-transmit loopback with a packet parser. Each packet is an opcode, an operand count, and little-endian operands. The block folds the operands through the selected operation and streams the result back, or forwards the operands verbatim in ECHO mode. An inter-byte timeout keeps a truncated packet from locking up the parser.

## Interface
Parameters:
- `OPERAND_BYTES`, default 4: bytes per operand and per result. Operand width W = 8·OPERAND_BYTES.
- `TIMEOUT_CYCLES`, default 1_000_000: idle clocks allowed between bytes inside a packet. 0 disables the timeout.
- `ERR_BYTE`, default 8'hEE: the single-byte error response.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 8: received byte, driven by `uart_rx`.
- `s_axis_tvalid` in 1: received byte valid.
- `s_axis_tready` out 1: block can accept a byte.
- `m_axis_tdata` out 8: byte to transmit, sent to `uart_tx`.
- `m_axis_tvalid` out 1: transmit byte valid.
- `m_axis_tready` in 1: `uart_tx` accepts the byte.
- `busy` out 1: high whenever state ≠ IDLE.
- `err_o` out 1: one-cycle pulse on a bad opcode, a zero count, or a timeout.

## Operation
- **Packet format:** `[opcode][count N][N × OPERAND_BYTES operand bytes, LSB first]`.
- **Opcodes:**
  - 0x00 ECHO
  - 0x01 ADD
  - 0x02 MUL
  - 0x03 XOR
  - 0x04 MAX (unsigned)
  - Any other value is illegal.
- **Accumulator initial value:** 0 for ADD, XOR and MAX; 1 for MUL. The result is the operands folded in arrival order, modulo 2^W.
- **States:**
  - IDLE: accept an opcode. An illegal opcode goes to ERR; any legal opcode goes to COUNT.
  - COUNT: accept N.
    - N = 0 with an arithmetic opcode goes to ERR.
    - N = 0 with ECHO goes to IDLE with no output.
    - Otherwise go to OPERAND.
  - OPERAND: shift bytes into the operand register. After the last byte of each operand, go to APPLY.
  - APPLY: one cycle for ADD, XOR and MAX. For MUL, hand off to the sub-multiplier and wait for its done signal (W cycles). Then return to OPERAND, or go to RESULT if this was the last operand.
  - RESULT: emit OPERAND_BYTES bytes of the accumulator, LSB first, then go to IDLE.
  - ERR: emit ERR_BYTE once, then go to IDLE.
- **ECHO:** in OPERAND, each accepted byte is forwarded through the output register. `s_axis_tready = !m_axis_tvalid || m_axis_tready`. No APPLY or RESULT phase. Return to IDLE after the last byte is accepted.
- **Timeout:** applies in COUNT and OPERAND (all opcodes). The counter clears on every accepted byte. When it reaches TIMEOUT_CYCLES, the block pulses `err_o`, goes to IDLE, discards the partial packet and sends no response.
- **Simultaneous events:** if a byte is accepted on the same cycle the counter hits its limit, the byte wins and the timeout does not fire.
- **Reset mid-operation:** all state is dropped asynchronously. A partially sent response is abandoned.

## Timing
- **Reset values:** `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `err_o`=0. `s_axis_tready` is registered and rises on the first clock after `rst` deasserts.
- **Input acceptance:** a byte is accepted when `s_axis_tvalid & s_axis_tready` are both high on a rising `clk` edge.
  - `s_axis_tready`=1 in IDLE, COUNT and non-ECHO OPERAND.
  - `s_axis_tready`=0 in APPLY, RESULT and ERR.
- **Output handshake:** once `m_axis_tvalid` is high, `m_axis_tdata` holds stable until `m_axis_tready`. Valid never drops without a handshake, except on reset.
- **Latency, ADD/XOR/MAX:** the first result byte is valid 2 cycles after the final operand byte is accepted (one cycle for APPLY, one for the output register load).
- **Latency, MUL:** W+2 cycles after the final operand byte is accepted.
- **Latency, ERR:** ERR_BYTE is valid 1 cycle after the offending byte is accepted.
- **Back-to-back bytes:** with `m_axis_tready` held high, result bytes leave at one byte per cycle.
- **`err_o` timing:** pulses in the cycle the block enters ERR, or in the cycle the timeout fires.

## Structure
- **Package `uart_alu_pkg`:** opcode enum `alu_op_e`, state enum `alu_state_e`, `ERR_BYTE_DEFAULT`.
- **Sub-module `uart_alu_mul`:** iterative shift-add W×W→W multiplier.
  - Ports: `start`, `a`, `b`, `done`, `p`.
  - Takes W cycles; `done` pulses for one cycle.
  - Same clock and reset as the parent.
- The result shift-out and operand shift-in registers stay in `uart_alu_core`.

## Test plan
- **ADD:** send 01 02, 01 00 00 00, 02 00 00 00 → output 03 00 00 00. `err_o` stays low.
- **MUL:**
  - Send 02 03 with operands 3, 5, 7 → output 69 00 00 00.
  - Send 02 02 with operands 0x00010000, 0x00010000 → output 00 00 00 00 (wraps modulo 2^32).
- **Illegal opcode then valid packet:** send 7F → one `err_o` pulse and output EE. Then send 04 02 with operands 5, 9 → output 09 00 00 00.
- **Timeout:** use TIMEOUT_CYCLES=100. Send 01 02 00, then hold `s_axis_tvalid` low for 101 cycles → `err_o` pulses and there is no output. The block is back in IDLE, and a following ADD packet returns the correct sum.
- **ECHO with backpressure:** send 00 01 AA BB CC DD with `m_axis_tready` toggling every other cycle → output AA BB CC DD in order, with no drops and no duplicates.
- **Reset mid-response:** assert `rst` low while the result is being sent (output stalled by holding `m_axis_tready` low) → `m_axis_tvalid` goes to 0 immediately. After release, `s_axis_tready` is 1 on the next cycle and a new packet is processed correctly.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU command processor.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OP_ECHO = 8'h00,
        OP_ADD  = 8'h01,
        OP_MUL  = 8'h02,
        OP_XOR  = 8'h03,
        OP_MAX  = 8'h04
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_OPERAND,
        ST_APPLY,
        ST_RESULT,
        ST_ERR
    } alu_state_e;

    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

    function automatic logic is_legal_op(input logic [7:0] code);
        return code <= OP_MAX;
    endfunction

endpackage

// File: rtl/uart_alu_mul.sv
// Iterative shift-add W x W -> W multiplier; done pulses once when p is valid.
module uart_alu_mul #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  prod_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    // The first partial product is folded in on the start edge so done lands W-1 edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                prod_q   <= b[0] ? a : '0;
                mcand_q  <= a << 1;
                mplier_q <= b >> 1;
                cnt_q    <= CW'(W - 1);
            end else if (cnt_q != '0) begin
                prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign p    = prod_q;

endmodule

// File: rtl/uart_alu_core.sv
// Packet parser between uart_rx and uart_tx: folds little-endian operands through an opcode
// and streams the accumulator back, echoes operands, or answers with a single error byte.
module uart_alu_core
    import uart_alu_pkg::*;
#(
    parameter int unsigned OPERAND_BYTES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy,
    output logic       err_o
);

    localparam int unsigned W  = 8 * OPERAND_BYTES;
    localparam int unsigned IW = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;

    alu_state_e    state;
    alu_op_e       op_q;
    logic [7:0]    cnt_q;
    logic [IW-1:0] bidx_q;
    logic [IW-1:0] ridx_q;
    logic [W-1:0]  opnd_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  res_q;
    logic [31:0]   tmo_q;
    logic          run_q;
    logic          mul_pend_q;
    logic [7:0]    m_tdata_q;
    logic          m_tvalid_q;
    logic          err_q;

    logic          accepts;
    logic          echo_op;
    logic          out_free;
    logic          s_fire;
    logic          last_byte;
    logic          last_ridx;
    logic          tmo_hit;
    logic [W+7:0]  opnd_ext;
    logic [W-1:0]  opnd_next;
    logic          mul_start;
    logic          mul_done;
    logic [W-1:0]  mul_p;
    logic [W-1:0]  apply_val;
    logic          apply_done;

    always_comb begin
        accepts   = (state == ST_IDLE) || (state == ST_COUNT) || (state == ST_OPERAND);
        echo_op   = (state == ST_OPERAND) && (op_q == OP_ECHO);
        out_free  = !m_tvalid_q || m_axis_tready;
        s_axis_tready = run_q && accepts && (!echo_op || out_free);
        s_fire    = s_axis_tvalid && s_axis_tready;
        last_byte = (bidx_q == IW'(OPERAND_BYTES - 1));
        last_ridx = (ridx_q == IW'(OPERAND_BYTES - 1));
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES - 1);
        opnd_ext  = {s_axis_tdata, opnd_q};
        opnd_next = opnd_ext[W+7:8];
        mul_start = (state == ST_APPLY) && (op_q == OP_MUL) && !mul_pend_q;
        apply_done = (op_q != OP_MUL) || mul_done;
        case (op_q)
            OP_ADD:  apply_val = acc_q + opnd_q;
            OP_MUL:  apply_val = mul_p;
            OP_XOR:  apply_val = acc_q ^ opnd_q;
            OP_MAX:  apply_val = (opnd_q > acc_q) ? opnd_q : acc_q;
            default: apply_val = acc_q;
        endcase
    end

    uart_alu_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (acc_q),
        .b     (opnd_q),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_ECHO;
            cnt_q      <= '0;
            bidx_q     <= '0;
            ridx_q     <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            tmo_q      <= '0;
            run_q      <= 1'b0;
            mul_pend_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            err_q <= 1'b0;
            if (m_tvalid_q && m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
            if ((state == ST_COUNT) || (state == ST_OPERAND)) begin
                tmo_q <= s_fire ? '0 : tmo_q + 32'd1;
            end else begin
                tmo_q <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (s_fire) begin
                        if (is_legal_op(s_axis_tdata)) begin
                            op_q  <= alu_op_e'(s_axis_tdata);
                            state <= ST_COUNT;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_ERR;
                        end
                    end
                end
                ST_COUNT: begin
                    if (s_fire) begin
                        cnt_q  <= s_axis_tdata;
                        bidx_q <= '0;
                        acc_q  <= (op_q == OP_MUL) ? W'(1) : '0;
                        if (s_axis_tdata != 8'd0) begin
                            state <= ST_OPERAND;
                        end else if (op_q == OP_ECHO) begin
                            state <= ST_IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_ERR;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_OPERAND: begin
                    if (s_fire) begin
                        opnd_q <= opnd_next;
                        bidx_q <= last_byte ? '0 : bidx_q + 1'b1;
                        if (op_q == OP_ECHO) begin
                            m_tdata_q  <= s_axis_tdata;
                            m_tvalid_q <= 1'b1;
                            if (last_byte) begin
                                cnt_q <= cnt_q - 8'd1;
                                if (cnt_q == 8'd1) begin
                                    state <= ST_IDLE;
                                end
                            end
                        end else if (last_byte) begin
                            state <= ST_APPLY;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (mul_start) begin
                        mul_pend_q <= 1'b1;
                    end
                    if (apply_done) begin
                        mul_pend_q <= 1'b0;
                        acc_q      <= apply_val;
                        cnt_q      <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            res_q  <= apply_val;
                            ridx_q <= '0;
                            state  <= ST_RESULT;
                        end else begin
                            state <= ST_OPERAND;
                        end
                    end
                end
                ST_RESULT: begin
                    // The last byte is only loaded here; its handshake completes from IDLE.
                    if (out_free) begin
                        m_tdata_q  <= res_q[7:0];
                        m_tvalid_q <= 1'b1;
                        res_q      <= res_q >> 8;
                        ridx_q     <= ridx_q + 1'b1;
                        if (last_ridx) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    if (out_free) begin
                        m_tdata_q  <= ERR_BYTE;
                        m_tvalid_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign busy          = (state != ST_IDLE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_uart_alu_core.sv
// Randomised self-checking bench for uart_alu_core against a packet-level reference model.
module tb_uart_alu_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       busy;
    logic       err_o;

    int         tests_run = 0;
    int         fails     = 0;
    int         err_cnt   = 0;
    int         tr_mode   = 0;
    int         exp_err;
    logic [7:0] got[$];
    logic [7:0] pkt_q[$];
    logic [7:0] exp_q[$];

    uart_alu_core #(
        .OPERAND_BYTES  (4),
        .TIMEOUT_CYCLES (100),
        .ERR_BYTE       (8'hEE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    // Inputs are stable at the falling edge, so a handshake seen here completes on the next rise.
    always @(negedge clk) begin
        if (rst && m_tvalid && m_tready) got.push_back(m_tdata);
        if (rst && err_o) err_cnt++;
    end

    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, elapsed=%0t required=finish", $time);
        $fatal(1);
    end

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    // Reference model: byte stream in, expected response bytes and error pulse count out.
    function automatic void build(input logic [7:0] op, input logic [31:0] v[$]);
        logic [31:0] acc;
        pkt_q.delete();
        exp_q.delete();
        exp_err = 0;
        pkt_q.push_back(op);
        if (op > 8'h04) begin
            exp_q.push_back(8'hEE);
            exp_err = 1;
            return;
        end
        pkt_q.push_back(8'(v.size()));
        if (v.size() == 0) begin
            if (op != 8'h00) begin
                exp_q.push_back(8'hEE);
                exp_err = 1;
            end
            return;
        end
        foreach (v[i]) for (int b = 0; b < 4; b++) pkt_q.push_back(v[i][8*b +: 8]);
        if (op == 8'h00) begin
            for (int i = 2; i < pkt_q.size(); i++) exp_q.push_back(pkt_q[i]);
        end else begin
            acc = (op == 8'h02) ? 32'd1 : 32'd0;
            foreach (v[i]) begin
                case (op)
                    8'h01:   acc = acc + v[i];
                    8'h02:   acc = acc * v[i];
                    8'h03:   acc = acc ^ v[i];
                    default: acc = (v[i] > acc) ? v[i] : acc;
                endcase
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit took = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!took && n < 1000) begin
            @(negedge clk);
            took = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        if (!took) begin
            tests_run++;
            fails++;
            $display("FAIL send_byte: byte %02h not accepted, waited=%0d cycles required=<1000", b, n);
        end
    endtask

    task automatic send_packet(input int gmax);
        foreach (pkt_q[i]) begin
            repeat ($urandom_range(0, gmax)) begin
                @(posedge clk);
                #1;
            end
            send_byte(pkt_q[i]);
        end
    endtask

    task automatic collect(input int nexp);
        int n = 0;
        while ((got.size() < nexp || busy || m_tvalid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            tests_run++;
            fails++;
            $display("FAIL collect: got %0d bytes, required %0d within 2000 cycles", got.size(), nexp);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b required 0", s_tready); end
        tests_run++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); end
        tests_run++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL reset_m_tdata: got %02h required 00", m_tdata); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err_o: got %b required 0", err_o); end
        rst = 1'b1;
        #1;
        tests_run++; if (s_tready !== 1'b0) begin fails++; $display("FAIL release_s_tready_early: got %b required 0", s_tready); end
        @(posedge clk);
        #1;
        tests_run++; if (s_tready !== 1'b1) begin fails++; $display("FAIL release_s_tready: got %b required 1", s_tready); end
    endtask

    task automatic test_add;
        logic [31:0] v[$];
        int e0, lat, hi;
        tr_mode = 0;
        got.delete();
        e0 = err_cnt;
        v = '{32'd1, 32'd2};
        build(8'h01, v);
        send_packet(0);
        lat = 0;
        while (!m_tvalid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++; if (lat !== 2) begin fails++; $display("FAIL add_latency: got %0d cycles required 2", lat); end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_tvalid) hi++;
            @(posedge clk);
            #1;
        end
        tests_run++; if (hi !== 4) begin fails++; $display("FAIL add_back_to_back: got %0d valid cycles required 4", hi); end
        collect(exp_q.size());
        tests_run++; if (q2s(got) != q2s(exp_q)) begin fails++; $display("FAIL add_result: got '%s' required '%s'", q2s(got), q2s(exp_q)); end
        tests_run++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL add_err: got %0d pulses required 0", err_cnt - e0); end
    endtask

    task automatic test_mul;
        logic [31:0] v[$];
        int lat;
        tr_mode = 0;
        got.delete();
        v = '{32'd3, 32'd5, 32'd7};
        build(8'h02, v);
        send_packet(1);
        lat = 0;
        while (!m_tvalid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++; if (lat !== 34) begin fails++; $display("FAIL mul_latency: got %0d cycles required 34", lat); end
        collect(exp_q.size());
        tests_run++; if (q2s(got) != "69 00 00 00 ") begin fails++; $display("FAIL mul_result: got '%s' required '69 00 00 00 '", q2s(got)); end
        got.delete();
        v = '{32'h0001_0000, 32'h0001_0000};
        build(8'h02, v);
        send_packet(0);
        collect(exp_q.size());
        tests_run++; if (q2s(got) != "00 00 00 00 ") begin fails++; $display("FAIL mul_wrap: got '%s' required '00 00 00 00 '", q2s(got)); end
    endtask

    task automatic test_illegal;
        logic [31:0] v[$];
        int e0, lat;
        tr_mode = 0;
        got.delete();
        e0 = err_cnt;
        v = {};
        build(8'h7F, v);
        send_packet(0);
        lat = 0;
        while (!m_tvalid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++; if (lat !== 1) begin fails++; $display("FAIL err_latency: got %0d cycles required 1", lat); end
        collect(1);
        tests_run++; if (q2s(got) != "ee ") begin fails++; $display("FAIL illegal_resp: got '%s' required 'ee '", q2s(got)); end
        tests_run++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL illegal_err: got %0d pulses required 1", err_cnt - e0); end
        got.delete();
        v = '{32'd5, 32'd9};
        build(8'h04, v);
        send_packet(2);
        collect(4);
        tests_run++; if (q2s(got) != "09 00 00 00 ") begin fails++; $display("FAIL max_after_err: got '%s' required '09 00 00 00 '", q2s(got)); end
        got.delete();
        e0 = err_cnt;
        v = {};
        build(8'h01, v);
        send_packet(0);
        collect(1);
        tests_run++; if (q2s(got) != "ee ") begin fails++; $display("FAIL zero_count_resp: got '%s' required 'ee '", q2s(got)); end
        tests_run++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL zero_count_err: got %0d pulses required 1", err_cnt - e0); end
        got.delete();
        e0 = err_cnt;
        build(8'h00, v);
        send_packet(0);
        collect(0);
        tests_run++; if (got.size() !== 0 || err_cnt - e0 !== 0) begin fails++; $display("FAIL echo_zero: got %0d bytes %0d pulses required 0 and 0", got.size(), err_cnt - e0); end
    endtask

    task automatic test_timeout;
        logic [31:0] v[$];
        int e0;
        tr_mode = 0;
        got.delete();
        e0 = err_cnt;
        pkt_q = '{8'h01, 8'h02, 8'h00};
        send_packet(0);
        repeat (99) begin
            @(posedge clk);
            #1;
        end
        tests_run++; if (err_cnt - e0 !== 0 || busy !== 1'b1) begin fails++; $display("FAIL timeout_early: got %0d pulses busy=%b required 0 pulses busy=1", err_cnt - e0, busy); end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        tests_run++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d pulses required 1", err_cnt - e0); end
        tests_run++; if (busy !== 1'b0 || got.size() !== 0) begin fails++; $display("FAIL timeout_idle: got busy=%b bytes=%0d required busy=0 bytes=0", busy, got.size()); end
        v = '{32'h1234_5610, 32'h0000_0020};
        build(8'h01, v);
        send_packet(1);
        collect(4);
        tests_run++; if (q2s(got) != "30 56 34 12 ") begin fails++; $display("FAIL add_after_timeout: got '%s' required '30 56 34 12 '", q2s(got)); end
    endtask

    task automatic test_echo_backpressure;
        logic [31:0] v[$];
        int e0;
        tr_mode = 1;
        got.delete();
        e0 = err_cnt;
        v = '{32'hDDCC_BBAA};
        build(8'h00, v);
        send_packet(0);
        collect(4);
        tests_run++; if (q2s(got) != "aa bb cc dd ") begin fails++; $display("FAIL echo_bp: got '%s' required 'aa bb cc dd '", q2s(got)); end
        tests_run++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL echo_err: got %0d pulses required 0", err_cnt - e0); end
        tr_mode = 0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] v[$];
        int n;
        tr_mode = 3;
        got.delete();
        v = '{32'd10, 32'd20};
        build(8'h01, v);
        send_packet(0);
        n = 0;
        while (!m_tvalid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b required 1", m_tvalid); end
        rst = 1'b0;
        #1;
        tests_run++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_mid: got valid=%b busy=%b required 0 0", m_tvalid, busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        got.delete();
        tr_mode = 0;
        @(posedge clk);
        #1;
        tests_run++; if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_mid_ready: got %b required 1", s_tready); end
        v = '{32'h0000_00F0, 32'h0000_0011};
        build(8'h03, v);
        send_packet(0);
        collect(4);
        tests_run++; if (q2s(got) != "e1 00 00 00 ") begin fails++; $display("FAIL xor_after_reset: got '%s' required 'e1 00 00 00 '", q2s(got)); end
    endtask

    task automatic test_random;
        logic [31:0] v[$];
        logic [7:0]  op;
        int r, n, e0;
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 11);
            op = (r < 10) ? 8'(r % 5) : 8'(5 + $urandom_range(0, 250));
            n  = $urandom_range(0, 4);
            v.delete();
            for (int i = 0; i < n; i++) v.push_back(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom()));
            tr_mode = $urandom_range(0, 2);
            got.delete();
            e0 = err_cnt;
            build(op, v);
            send_packet(3);
            collect(exp_q.size());
            tests_run++; if (q2s(got) != q2s(exp_q)) begin fails++; $display("FAIL rand_%0d op=%02h n=%0d: got '%s' required '%s'", k, op, n, q2s(got), q2s(exp_q)); end
            tests_run++; if (err_cnt - e0 !== exp_err) begin fails++; $display("FAIL rand_err_%0d op=%02h: got %0d pulses required %0d", k, op, err_cnt - e0, exp_err); end
        end
        tr_mode = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_timeout();
        test_echo_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
